// File: rtl/opc6_pkg.sv
// -----------------------------------------------------------------------------
// opc6_pkg
// Shared constants for the opc6 bus responder: I/O register offsets
// (address[2:0] of an I/O cycle), TMR_CTRL / IRQ_STAT bit positions and the
// responder FSM state encodings.
// -----------------------------------------------------------------------------
package opc6_pkg;

    // I/O register offsets
    localparam logic [2:0] IO_TMR_RELOAD = 3'd0;
    localparam logic [2:0] IO_TMR_COUNT  = 3'd1;
    localparam logic [2:0] IO_TMR_CTRL   = 3'd2;
    localparam logic [2:0] IO_IRQ_STAT   = 3'd3;
    localparam logic [2:0] IO_GPIO_OUT   = 3'd4;
    localparam logic [2:0] IO_GPIO_IN    = 3'd5;

    // TMR_CTRL bit indices
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;

    // IRQ_STAT bit indices (also the int_b bit each source drives)
    localparam int IRQ_TIMER = 0;
    localparam int IRQ_EXT   = 1;

    // Responder FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/opc6_timer.sv
// -----------------------------------------------------------------------------
// opc6_timer
// Reload/count down-timer with control register. While run=1 the count
// decrements every clock; on reaching zero it reloads and pulses o_expire.
// Ports:
//   clk, reset_b      clock, asynchronous active-low reset
//   i_wr_reload      write strobe for TMR_RELOAD (data on i_wdata)
//   i_wr_ctrl        write strobe for TMR_CTRL   (data on i_wdata)
//   i_wdata[15:0]    write data
//   o_reload/o_count current TMR_RELOAD / TMR_COUNT
//   o_ctrl[1:0]      current TMR_CTRL (run, irq_en)
//   o_expire         one-cycle pulse, high in the cycle whose edge reloads
// -----------------------------------------------------------------------------
module opc6_timer
    import opc6_pkg::*;
(
    input  logic        clk,
    input  logic        reset_b,
    input  logic        i_wr_reload,
    input  logic        i_wr_ctrl,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_reload,
    output logic [15:0] o_count,
    output logic [1:0]  o_ctrl,
    output logic        o_expire
);

    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic [1:0]  r_ctrl;
    logic        w_run;
    logic        w_start;

    assign w_run    = r_ctrl[CTRL_RUN];
    // A run 0->1 transition restarts the count from the reload value.
    assign w_start  = i_wr_ctrl & i_wdata[CTRL_RUN] & ~r_ctrl[CTRL_RUN];
    assign o_expire = w_run & (r_count == 16'd0);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_reload <= 16'd0;
            r_count  <= 16'd0;
            r_ctrl   <= 2'b00;
        end else begin
            if (i_wr_reload)
                r_reload <= i_wdata;
            if (i_wr_ctrl)
                r_ctrl <= i_wdata[1:0];
            // Reload uses the pre-edge r_reload, so a RELOAD write only
            // affects the following reload.
            if (w_start)
                r_count <= r_reload;
            else if (w_run)
                r_count <= (r_count == 16'd0) ? r_reload : r_count - 16'd1;
        end
    end

    assign o_reload = r_reload;
    assign o_count  = r_count;
    assign o_ctrl   = r_ctrl;

endmodule

// File: rtl/opc6_bus_responder.sv
// -----------------------------------------------------------------------------
// opc6_bus_responder
// Sole bus target for opc6cpu: on-chip RAM with programmable wait states, an
// I/O register file (timer, IRQ status, GPIO), CPU clock enable and the two
// active-low interrupt lines.
// Ports:
//   clk, reset_b        clock, asynchronous active-low reset
//   vpa, vda, vio, rnw  CPU fetch / data / I/O strobes, 1=read
//   address[15:0]       CPU word address
//   cpu_dout[15:0]      CPU write data
//   din[15:0]           read data to CPU (valid the cycle after capture)
//   clken               CPU clock enable, 0 = stall
//   int_b[1:0]          [0] timer IRQ, [1] external IRQ, active-low
//   irq_ext_b           asynchronous external IRQ, active-low
//   gpio_in/gpio_out    general-purpose inputs (async) / outputs
//   o_dbg_state         current FSM state (ST_IDLE / ST_WAIT)
//
// Handshake: a request is "valid" when any of vpa/vda/vio is high and the
// responder is "ready" when clken is high; a transfer happens on a rising
// edge where both hold. Writes commit on that edge, read data appears on din
// after it and stays there until the next read transfer.
// -----------------------------------------------------------------------------
module opc6_bus_responder
    import opc6_pkg::*;
#(
    parameter int    MEM_AW      = 11,
    parameter int    WAIT_STATES = 0,
    parameter string MEM_INIT    = ""
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        vpa,
    input  logic        vda,
    input  logic        vio,
    input  logic        rnw,
    input  logic [15:0] address,
    input  logic [15:0] cpu_dout,
    output logic [15:0] din,
    output logic        clken,
    output logic [1:0]  int_b,
    input  logic        irq_ext_b,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [0:0]  o_dbg_state
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    logic [15:0]       r_mem [0:(1<<MEM_AW)-1];
    logic [0:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [15:0]       r_din;
    logic [15:0]       r_gpio_out;
    logic              r_irq_timer;
    logic              r_int0_b;
    logic              r_ext_s1, r_ext_s2;
    logic [15:0]       r_gpio_s1, r_gpio_s2;

    logic              w_capture, w_io, w_mem;
    logic              w_io_wr, w_rd;
    logic [2:0]        w_off;
    logic [MEM_AW-1:0] w_mem_addr;
    logic [15:0]       w_io_rdata;
    logic [15:0]       w_tmr_reload, w_tmr_count;
    logic [1:0]        w_tmr_ctrl;
    logic              w_tmr_expire;
    logic              w_unused_addr;

    // clken is high exactly when the FSM is idle; an asynchronous reset
    // therefore releases the stall immediately.
    assign clken       = (r_state == ST_IDLE);
    assign o_dbg_state = r_state;

    // vio outranks vpa/vda: an I/O cycle never touches RAM.
    assign w_capture  = clken & (vpa | vda | vio);
    assign w_io       = w_capture & vio;
    assign w_mem      = w_capture & ~vio;
    assign w_io_wr    = w_io & ~rnw;
    assign w_rd       = w_capture & rnw;
    assign w_off      = address[2:0];
    // Upper address bits are dropped, so RAM mirrors through the 64K space.
    assign w_mem_addr = address[MEM_AW-1:0];
    assign w_unused_addr = ^address[15:MEM_AW];

    // ---------------- FSM: wait-state stall ----------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem && (WAIT_CNT != 4'd0)) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= WAIT_CNT;
                    end
                end
                default: begin
                    // Leaves after WAIT_STATES cycles with clken low.
                    if (r_wait_cnt == 4'd1)
                        r_state <= ST_IDLE;
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end
            endcase
        end
    end

    // ---------------- RAM (not cleared by reset) ----------------
    always_ff @(posedge clk) begin
        if (w_mem && !rnw)
            r_mem[w_mem_addr] <= cpu_dout;
    end

    // ---------------- Timer ----------------
    opc6_timer u_timer (
        .clk        (clk),
        .reset_b    (reset_b),
        .i_wr_reload(w_io_wr && (w_off == IO_TMR_RELOAD)),
        .i_wr_ctrl  (w_io_wr && (w_off == IO_TMR_CTRL)),
        .i_wdata    (cpu_dout),
        .o_reload   (w_tmr_reload),
        .o_count    (w_tmr_count),
        .o_ctrl     (w_tmr_ctrl),
        .o_expire   (w_tmr_expire)
    );

    // ---------------- I/O read mux ----------------
    always_comb begin
        w_io_rdata = 16'd0;
        case (w_off)
            IO_TMR_RELOAD: w_io_rdata = w_tmr_reload;
            IO_TMR_COUNT:  w_io_rdata = w_tmr_count;
            IO_TMR_CTRL:   w_io_rdata = {14'd0, w_tmr_ctrl};
            IO_IRQ_STAT:   w_io_rdata = {14'd0, ~r_ext_s2, r_irq_timer};
            IO_GPIO_OUT:   w_io_rdata = r_gpio_out;
            IO_GPIO_IN:    w_io_rdata = r_gpio_s2;
            default:       w_io_rdata = 16'd0;
        endcase
    end

    // ---------------- Read data, I/O registers, IRQs, synchronisers ----------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_din       <= 16'd0;
            r_gpio_out  <= 16'd0;
            r_irq_timer <= 1'b0;
            r_int0_b    <= 1'b1;
            r_ext_s1    <= 1'b1;
            r_ext_s2    <= 1'b1;
            r_gpio_s1   <= 16'd0;
            r_gpio_s2   <= 16'd0;
        end else begin
            if (w_rd)
                r_din <= vio ? w_io_rdata : r_mem[w_mem_addr];
            if (w_io_wr && (w_off == IO_GPIO_OUT))
                r_gpio_out <= cpu_dout;
            // Expiry takes precedence over a simultaneous write-1-to-clear.
            if (w_tmr_expire)
                r_irq_timer <= 1'b1;
            else if (w_io_wr && (w_off == IO_IRQ_STAT) && cpu_dout[IRQ_TIMER])
                r_irq_timer <= 1'b0;
            r_int0_b  <= ~(r_irq_timer & w_tmr_ctrl[CTRL_IRQ_EN]);
            r_ext_s1  <= irq_ext_b;
            r_ext_s2  <= r_ext_s1;
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
        end
    end

    assign din      = r_din;
    assign gpio_out = r_gpio_out;
    assign int_b    = {r_ext_s2, r_int0_b};

endmodule

// File: tb/tb_opc6_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_opc6_bus_responder
// Two responders share one CPU-side stimulus: u_dut0 (WAIT_STATES=0) carries
// the main bus/IO checks through a read scoreboard, u_dut3 (WAIT_STATES=3)
// covers the stall behaviour and reset during WAIT.
// -----------------------------------------------------------------------------
module tb_opc6_bus_responder;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        vpa, vda, vio, rnw;
    logic [15:0] address, cpu_dout;
    logic        irq_ext_b;
    logic [15:0] gpio_in;

    logic [15:0] din0, din3, gpio_out0, gpio_out3;
    logic        clken0, clken3;
    logic [1:0]  int_b0, int_b3;
    logic [0:0]  dbg0, dbg3;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        rd_pend = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    opc6_bus_responder #(.MEM_AW(11), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_b(reset_b), .vpa(vpa), .vda(vda), .vio(vio), .rnw(rnw),
        .address(address), .cpu_dout(cpu_dout), .din(din0), .clken(clken0),
        .int_b(int_b0), .irq_ext_b(irq_ext_b), .gpio_in(gpio_in),
        .gpio_out(gpio_out0), .o_dbg_state(dbg0)
    );

    opc6_bus_responder #(.MEM_AW(11), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset_b(reset_b), .vpa(vpa), .vda(vda), .vio(vio), .rnw(rnw),
        .address(address), .cpu_dout(cpu_dout), .din(din3), .clken(clken3),
        .int_b(int_b3), .irq_ext_b(irq_ext_b), .gpio_in(gpio_in),
        .gpio_out(gpio_out3), .o_dbg_state(dbg3)
    );

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives one request for one cycle, returns at the
    // following posedge+1 with all strobes low.
    task automatic bus_op(input logic p, input logic d, input logic io, input logic r,
                          input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp, input string name);
        vpa = p; vda = d; vio = io; rnw = r;
        address = a; cpu_dout = wd;
        if (r) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        @(posedge clk); #1;
        vpa = 1'b0; vda = 1'b0; vio = 1'b0; rnw = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // u_dut0 never stalls, so every read strobe seen at an edge is a transfer
    // whose data is due on din0 before the next edge.
    always @(posedge clk)
        rd_pend <= reset_b && clken0 && (vpa || vda || vio) && rnw;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected_read: got 0x%04h expected no read", din0);
            end else begin
                logic [15:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, din0, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_b = 1'b0;
        vpa = 1'b0; vda = 1'b0; vio = 1'b0; rnw = 1'b1;
        address = 16'd0; cpu_dout = 16'd0;
        irq_ext_b = 1'b1; gpio_in = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_din",      din0,      16'h0000);
        check("rst_clken",    {15'd0, clken0}, 16'd1);
        check("rst_int_b",    {14'd0, int_b0}, 16'h0003);
        check("rst_gpio_out", gpio_out0, 16'h0000);
        check("rst_clken3",   {15'd0, clken3}, 16'd1);
        check("rst_state3",   {15'd0, dbg3},   16'd0);
        reset_b = 1'b1;
        @(posedge clk); #1;

        // ---- wait-state fetch on u_dut3 ----
        bus_op(0, 1, 0, 0, 16'h0020, 16'hBEEF, 16'h0, "");
        idle(4);
        bus_op(1, 0, 0, 1, 16'h0020, 16'h0, 16'hBEEF, "fetch_0020");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("ws3_clken_%0d", i), {15'd0, clken3}, (i == 3) ? 16'd1 : 16'd0);
            check($sformatf("ws3_din_%0d", i), din3, 16'hBEEF);
            if (i == 0) begin
                check("ws3_state_wait", {15'd0, dbg3}, 16'd1);
                check("ws0_clken_fetch", {15'd0, clken0}, 16'd1);
            end
        end
        @(posedge clk); #1;

        // ---- zero-wait RAM read and mirroring ----
        bus_op(0, 1, 0, 0, 16'h0010, 16'h1234, 16'h0, "");
        bus_op(0, 1, 0, 1, 16'h0010, 16'h0, 16'h1234, "ram_rd_0010");
        @(negedge clk);
        check("ws0_clken_rd", {15'd0, clken0}, 16'd1);
        @(posedge clk); #1;
        bus_op(0, 1, 0, 0, 16'h0809, 16'h5A5A, 16'h0, "");
        bus_op(0, 1, 0, 1, 16'h0009, 16'h0, 16'h5A5A, "alias_0009");
        idle(3);
        @(negedge clk);
        check("din_hold_idle", din0, 16'h5A5A);
        @(posedge clk); #1;

        // ---- GPIO and unused offsets ----
        bus_op(0, 0, 1, 0, 16'h0004, 16'hA5A5, 16'h0, "");
        bus_op(0, 0, 1, 1, 16'h0004, 16'h0, 16'hA5A5, "gpio_out_rd");
        @(negedge clk);
        check("gpio_out_pin", gpio_out0, 16'hA5A5);
        @(posedge clk); #1;
        bus_op(0, 1, 1, 1, 16'hFFF4, 16'h0, 16'hA5A5, "vio_priority_hi_addr");
        bus_op(0, 0, 1, 0, 16'h0006, 16'hFFFF, 16'h0, "");
        bus_op(0, 0, 1, 1, 16'h0006, 16'h0, 16'h0000, "io_off6_rd");
        gpio_in = 16'h3C3C;
        idle(2);
        bus_op(0, 0, 1, 1, 16'h0005, 16'h0, 16'h3C3C, "gpio_in_rd");

        // ---- timer: reload 4, run + irq_en => expiry every 5 clk ----
        bus_op(0, 0, 1, 0, 16'h0000, 16'h0004, 16'h0, "");
        bus_op(0, 0, 1, 0, 16'h0002, 16'h0003, 16'h0, "");   // capture edge Ec
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("tmr_int0_k%0d", k), {15'd0, int_b0[0]}, (k < 6) ? 16'd1 : 16'd0);
        end
        @(posedge clk); #1;                                   // Ec+7
        idle(2);                                              // Ec+9
        bus_op(0, 0, 1, 0, 16'h0003, 16'h0001, 16'h0, "");   // W1C on expiry edge Ec+10
        bus_op(0, 0, 1, 1, 16'h0003, 16'h0, 16'h0001, "irq_set_wins");
        bus_op(0, 0, 1, 0, 16'h0003, 16'h0001, 16'h0, "");   // clean W1C at Ec+12
        bus_op(0, 0, 1, 1, 16'h0003, 16'h0, 16'h0000, "irq_cleared");
        @(negedge clk);
        check("int0_released", {15'd0, int_b0[0]}, 16'd1);
        @(posedge clk); #1;
        idle(1);
        bus_op(0, 0, 1, 1, 16'h0003, 16'h0, 16'h0001, "irq_period");   // Ec+16
        bus_op(0, 0, 1, 1, 16'h0001, 16'h0, 16'h0003, "tmr_count");    // Ec+17
        @(negedge clk);
        check("int0_reasserted", {15'd0, int_b0[0]}, 16'd0);
        @(posedge clk); #1;
        bus_op(0, 0, 1, 1, 16'h0002, 16'h0, 16'h0003, "tmr_ctrl_rd");
        bus_op(0, 0, 1, 1, 16'h0000, 16'h0, 16'h0004, "tmr_reload_rd");
        bus_op(0, 0, 1, 0, 16'h0002, 16'h0000, 16'h0, "");
        bus_op(0, 0, 1, 0, 16'h0003, 16'h0001, 16'h0, "");

        // ---- external IRQ synchroniser ----
        irq_ext_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ext_irq_1clk", {15'd0, int_b0[1]}, 16'd1);
        @(negedge clk);
        check("ext_irq_2clk", {15'd0, int_b0[1]}, 16'd0);
        @(posedge clk); #1;
        bus_op(0, 0, 1, 1, 16'h0003, 16'h0, 16'h0002, "irq_stat_ext");

        // ---- reset asserted mid-WAIT ----
        idle(4);
        bus_op(0, 1, 0, 1, 16'h0020, 16'h0, 16'hBEEF, "ram_rd_pre_reset");
        @(negedge clk);
        check("pre_rst_clken3", {15'd0, clken3}, 16'd0);
        #2;
        reset_b = 1'b0;
        #1;
        check("rst_wait_clken3", {15'd0, clken3}, 16'd1);
        check("rst_wait_din3",   din3, 16'h0000);
        check("rst_wait_state3", {15'd0, dbg3}, 16'd0);
        check("rst_wait_din0",   din0, 16'h0000);
        check("rst_wait_int_b3", {14'd0, int_b3}, 16'h0003);
        check("rst_wait_gpio",   gpio_out0, 16'h0000);
        @(posedge clk); #1;
        reset_b = 1'b1;
        irq_ext_b = 1'b1;
        idle(2);

        check("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
